// File: rtl/fp_vec3_normalize_folded_if.sv
// Handshake bundle for fp_vec3_normalize_folded: input vector, inverse-sqrt request/response, result.
// `WIDTH is the fixed-point word width and `FRAC_BITS the fraction bits (Q16.16 unless overridden).
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 16
`endif

// Every channel is valid/ready: a transfer happens on the rising edge where both are high;
// the producer holds its payload and valid stable until that edge (isqrt_valid_in is a one-cycle pulse).
interface fp_vec3_normalize_folded_if;
  logic [`WIDTH-1:0] x_in;
  logic [`WIDTH-1:0] y_in;
  logic [`WIDTH-1:0] z_in;
  logic              valid_in;
  logic              ready_out;
  logic [`WIDTH-1:0] isqrt_a_out;
  logic              isqrt_valid_out;
  logic              isqrt_ready_in;
  logic [`WIDTH-1:0] isqrt_res_in;
  logic              isqrt_valid_in;
  logic [`WIDTH-1:0] x_out;
  logic [`WIDTH-1:0] y_out;
  logic [`WIDTH-1:0] z_out;
  logic              zero_out;
  logic              valid_out;
  logic              ready_in;

  modport slave (
    input  x_in, y_in, z_in, valid_in,
    output ready_out,
    output isqrt_a_out, isqrt_valid_out,
    input  isqrt_ready_in, isqrt_res_in, isqrt_valid_in,
    output x_out, y_out, z_out, zero_out, valid_out,
    input  ready_in
  );

  modport master (
    output x_in, y_in, z_in, valid_in,
    input  ready_out,
    input  isqrt_a_out, isqrt_valid_out,
    output isqrt_ready_in, isqrt_res_in, isqrt_valid_in,
    input  x_out, y_out, z_out, zero_out, valid_out,
    output ready_in
  );
endinterface

// File: rtl/fp_vec3_normalize_folded.sv
// Normalizes a fixed-point 3-vector with one shared multiplier and an external inverse-sqrt unit.
// Optional macro FP_NORMALIZE_SAT_EN: saturate the |v|^2 accumulation instead of wrapping.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 16
`endif

module fp_vec3_normalize_folded #(
  parameter int ISQRT_TIMEOUT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  fp_vec3_normalize_folded_if.slave  bus,
  output logic [3:0]                 state_dbg
);
  localparam int W  = `WIDTH;
  localparam int F  = `FRAC_BITS;
  localparam int CW = (ISQRT_TIMEOUT > 1) ? $clog2(ISQRT_TIMEOUT) : 1;
  localparam bit TO_EN = (ISQRT_TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((ISQRT_TIMEOUT > 0) ? ISQRT_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SQ_X    = 4'd1,
    S_SQ_Y    = 4'd2,
    S_SQ_Z    = 4'd3,
    S_ISSUE   = 4'd4,
    S_WAIT    = 4'd5,
    S_SCALE_X = 4'd6,
    S_SCALE_Y = 4'd7,
    S_SCALE_Z = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t            state;
  logic [W-1:0]      xr, yr, zr, acc, res;
  logic [CW-1:0]     to_cnt;
  logic [W-1:0]      mul_a, mul_b, prod, sum;
  logic signed [2*W-1:0] prod_full;

  assign state_dbg = state;

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_SQ_X:    begin mul_a = xr; mul_b = xr;  end
      S_SQ_Y:    begin mul_a = yr; mul_b = yr;  end
      S_SQ_Z:    begin mul_a = zr; mul_b = zr;  end
      S_SCALE_X: begin mul_a = xr; mul_b = res; end
      S_SCALE_Y: begin mul_a = yr; mul_b = res; end
      S_SCALE_Z: begin mul_a = zr; mul_b = res; end
      default:   ;
    endcase
  end

  assign prod_full = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
  assign prod      = W'(prod_full >>> F);

`ifdef FP_NORMALIZE_SAT_EN
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  logic [W-1:0] sum_raw;
  assign sum_raw = acc + prod;
  // Once pinned at the maximum the sum stays there.
  assign sum = (acc == MAX_POS || sum_raw[W-1]) ? MAX_POS : sum_raw;
`else
  assign sum = acc + prod;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state               <= S_IDLE;
      bus.ready_out       <= 1'b1;
      bus.valid_out       <= 1'b0;
      bus.isqrt_valid_out <= 1'b0;
      bus.zero_out        <= 1'b0;
      bus.x_out           <= '0;
      bus.y_out           <= '0;
      bus.z_out           <= '0;
      bus.isqrt_a_out     <= '0;
      xr                  <= '0;
      yr                  <= '0;
      zr                  <= '0;
      acc                 <= '0;
      res                 <= '0;
      to_cnt              <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.valid_in) begin
            xr            <= bus.x_in;
            yr            <= bus.y_in;
            zr            <= bus.z_in;
            bus.ready_out <= 1'b0;
            state         <= S_SQ_X;
          end
        end
        S_SQ_X: begin
          acc   <= prod;
          state <= S_SQ_Y;
        end
        S_SQ_Y: begin
          acc   <= sum;
          state <= S_SQ_Z;
        end
        S_SQ_Z: begin
          if (sum == '0) begin
            bus.zero_out  <= 1'b1;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
            bus.z_out     <= '0;
            bus.valid_out <= 1'b1;
            state         <= S_DONE;
          end else begin
            bus.isqrt_a_out     <= sum;
            bus.isqrt_valid_out <= 1'b1;
            state               <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.isqrt_ready_in) begin
            bus.isqrt_valid_out <= 1'b0;
            to_cnt              <= '0;
            state               <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.isqrt_valid_in) begin
            res   <= bus.isqrt_res_in;
            state <= S_SCALE_X;
          end else if (TO_EN && to_cnt == TO_LAST) begin
            // Unit never answered: report as a degenerate vector.
            bus.zero_out  <= 1'b1;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
            bus.z_out     <= '0;
            bus.valid_out <= 1'b1;
            state         <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SCALE_X: begin
          bus.x_out <= prod;
          state     <= S_SCALE_Y;
        end
        S_SCALE_Y: begin
          bus.y_out <= prod;
          state     <= S_SCALE_Z;
        end
        S_SCALE_Z: begin
          bus.z_out     <= prod;
          bus.valid_out <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (bus.ready_in) begin
            bus.valid_out <= 1'b0;
            bus.zero_out  <= 1'b0;
            bus.ready_out <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_vec3_normalize_folded.sv
// Directed bench for fp_vec3_normalize_folded: fixed-point reference model, inverse-sqrt responder,
// scoreboard checked every cycle, plus a second instance with a short inverse-sqrt timeout.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 16
`endif

module tb_fp_vec3_normalize_folded;
  localparam int W = `WIDTH;
  localparam int F = `FRAC_BITS;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  fp_vec3_normalize_folded_if bus();
  fp_vec3_normalize_folded_if bus_to();
  logic [3:0] dbg_main, dbg_to;

  fp_vec3_normalize_folded u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus), .state_dbg(dbg_main)
  );

  fp_vec3_normalize_folded #(.ISQRT_TIMEOUT(8)) u_dut_to (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus_to), .state_dbg(dbg_to)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return W'(p >>> F);
  endfunction

  function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
`ifdef FP_NORMALIZE_SAT_EN
    if (a == MAXV || s[W-1]) s = MAXV;
`endif
    return s;
  endfunction

  function automatic logic [W-1:0] sumsq(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    return acc_add(acc_add(fmul(x, x), fmul(y, y)), fmul(z, z));
  endfunction

  // Ideal 1/sqrt in the same fixed-point format, truncated; non-positive input gives 0.
  function automatic logic [W-1:0] isqrt_model(input logic [W-1:0] a);
    real r;
    if ($signed(a) <= 0) return '0;
    r = (2.0 ** F) / $sqrt(real'(a) / (2.0 ** F));
    return W'($rtoi(r));
  endfunction

  typedef struct packed {
    logic         zero;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } res_t;

  res_t         exp_q[$];
  logic [W-1:0] exp_a_q[$];

  task automatic push_expect(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] s, r;
    res_t e;
    s = sumsq(x, y, z);
    if (s == '0) begin
      e = '{zero: 1'b1, x: '0, y: '0, z: '0};
    end else begin
      exp_a_q.push_back(s);
      r = isqrt_model(s);
      e = '{zero: 1'b0, x: fmul(x, r), y: fmul(y, r), z: fmul(z, r)};
    end
    exp_q.push_back(e);
  endtask

  // ---------------- inverse-sqrt responder for the main instance ----------------
  int unit_lat = 10;
  initial begin
    logic [W-1:0] a;
    bus.isqrt_valid_in = 1'b0;
    bus.isqrt_res_in   = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_in && bus.isqrt_valid_out && bus.isqrt_ready_in) begin
        a = bus.isqrt_a_out;
        @(posedge clk_in);
        repeat (unit_lat) @(posedge clk_in);
        #1;
        bus.isqrt_valid_in = 1'b1;
        bus.isqrt_res_in   = isqrt_model(a);
        @(posedge clk_in);
        #1;
        bus.isqrt_valid_in = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  res_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.isqrt_valid_out) begin
        if (exp_a_q.size() == 0) fail_event("sb_isqrt_req");
        else begin
          check("sb_isqrt_a", bus.isqrt_a_out, exp_a_q[0]);
          if (bus.isqrt_ready_in) void'(exp_a_q.pop_front());
        end
      end
      if (bus.valid_out) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) fail_event("sb_valid_out");
          else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          check("sb_x", bus.x_out, cur.x);
          check("sb_y", bus.y_out, cur.y);
          check("sb_z", bus.z_out, cur.z);
          check("sb_zero", bus.zero_out, cur.zero);
          check("sb_ready_out_low", bus.ready_out, 1'b0);
          if (bus.ready_in) have_cur = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                      output int acc_cyc);
    int n = 0;
    while (!bus.ready_out && n < 200) begin
      @(posedge clk_in); #1; n++;
    end
    check("send_ready_out", bus.ready_out, 1'b1);
    push_expect(x, y, z);
    bus.x_in = x; bus.y_in = y; bus.z_in = z;
    bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    acc_cyc = cyc;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int vcyc);
    int n = 0;
    while (!bus.valid_out && n < bound) begin
      @(posedge clk_in); #1; n++;
    end
    check("valid_out_seen", bus.valid_out, 1'b1);
    vcyc = cyc;
  endtask

  task automatic release_and_check;
    @(posedge clk_in); #1;
    check("release_ready_out", bus.ready_out, 1'b1);
    check("release_valid_out", bus.valid_out, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0, v0, n;
    rst_in = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0; bus.valid_in = 1'b0;
    bus.isqrt_ready_in = 1'b1; bus.ready_in = 1'b1;
    bus_to.x_in = '0; bus_to.y_in = '0; bus_to.z_in = '0; bus_to.valid_in = 1'b0;
    bus_to.isqrt_ready_in = 1'b1; bus_to.ready_in = 1'b1;
    bus_to.isqrt_valid_in = 1'b0; bus_to.isqrt_res_in = '0;
    #2 rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_ready_out", bus.ready_out, 1'b1);
    check("rst_valid_out", bus.valid_out, 1'b0);
    check("rst_isqrt_valid", bus.isqrt_valid_out, 1'b0);
    check("rst_zero_out", bus.zero_out, 1'b0);
    check("rst_x_out", bus.x_out, '0);
    check("rst_isqrt_a", bus.isqrt_a_out, '0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // (1.5, 2.0, 0): |v|^2 = 6.25, 1/sqrt = 0.4 -> 26214, outputs 39321 / 52428 / 0
    send(32'h0001_8000, 32'h0002_0000, 32'h0, a0);
    repeat (3) @(posedge clk_in);
    #1;
    check("issue_after_3", bus.isqrt_valid_out, 1'b1);
    check("issue_a_6p25", bus.isqrt_a_out, 32'h0006_4000);
    wait_valid(40, v0);
    check("basic_latency", v0 - a0, 18);
    check("basic_x", bus.x_out, 32'd39321);
    check("basic_y", bus.y_out, 32'd52428);
    check("basic_z", bus.z_out, 32'd0);
    check("basic_zero", bus.zero_out, 1'b0);
    release_and_check();

    // zero vector
    send('0, '0, '0, a0);
    wait_valid(20, v0);
    check("zero_latency", v0 - a0, 3);
    check("zero_flag", bus.zero_out, 1'b1);
    check("zero_x", bus.x_out, '0);
    release_and_check();

    // one LSB: its square underflows to 0
    send(32'h1, '0, '0, a0);
    wait_valid(20, v0);
    check("tiny_zero_flag", bus.zero_out, 1'b1);
    release_and_check();

    // (-3, 4, 0): 1/5 -> 13107, x = -39321
    send(32'hFFFD_0000, 32'h0004_0000, '0, a0);
    wait_valid(40, v0);
    check("neg_x", bus.x_out, 32'hFFFF_6667);
    check("neg_y", bus.y_out, 32'h0000_CCCC);
    release_and_check();

    // inverse-sqrt backpressure: (1, 2, 2), |v|^2 = 9
    bus.isqrt_ready_in = 1'b0;
    send(32'h0001_0000, 32'h0002_0000, 32'h0002_0000, a0);
    repeat (3) @(posedge clk_in);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      check("isq_bp_valid", bus.isqrt_valid_out, 1'b1);
      check("isq_bp_a", bus.isqrt_a_out, 32'h0009_0000);
    end
    bus.isqrt_ready_in = 1'b1;
    wait_valid(40, v0);
    check("isq_bp_x", bus.x_out, 32'd21845);
    release_and_check();

    // output backpressure: (0.5, 0, 0) -> x = 1.0
    bus.ready_in = 1'b0;
    send(32'h0000_8000, '0, '0, a0);
    wait_valid(40, v0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_in); #1;
      check("out_bp_valid", bus.valid_out, 1'b1);
      check("out_bp_ready_out", bus.ready_out, 1'b0);
      check("out_bp_x", bus.x_out, 32'h0001_0000);
    end
    bus.ready_in = 1'b1;
    release_and_check();

    // overflowing components
    send(MAXV, MAXV, MAXV, a0);
    repeat (3) @(posedge clk_in);
    #1;
`ifdef FP_NORMALIZE_SAT_EN
    check("ovf_a_sat", bus.isqrt_a_out, 32'h7FFF_FFFF);
`else
    check("ovf_issue", bus.isqrt_valid_out, 1'b1);
`endif
    wait_valid(40, v0);
    release_and_check();

    // asynchronous reset in the middle of WAIT; the late response must be ignored
    unit_lat = 20;
    send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, a0);
    repeat (6) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("arst_ready_out", bus.ready_out, 1'b1);
    check("arst_valid_out", bus.valid_out, 1'b0);
    check("arst_isqrt_valid", bus.isqrt_valid_out, 1'b0);
    exp_q.delete();
    exp_a_q.delete();
    have_cur = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (30) @(posedge clk_in);
    #1;
    check("late_pulse_valid_out", bus.valid_out, 1'b0);
    check("late_pulse_ready_out", bus.ready_out, 1'b1);
    unit_lat = 10;

    send(32'h0003_0000, 32'h0004_0000, '0, a0);
    wait_valid(40, v0);
    check("post_rst_x", bus.x_out, 32'd39321);
    release_and_check();

    // timeout instance: unit silent, abort after 8 WAIT cycles
    check("to_ready_idle", bus_to.ready_out, 1'b1);
    bus_to.x_in = 32'h0001_8000; bus_to.y_in = 32'h0002_0000; bus_to.z_in = '0;
    bus_to.valid_in = 1'b1;
    @(posedge clk_in); #1;
    a0 = cyc;
    bus_to.valid_in = 1'b0;
    n = 0;
    while (!bus_to.valid_out && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    check("to_valid_seen", bus_to.valid_out, 1'b1);
    check("to_latency", cyc - a0, 12);
    check("to_zero", bus_to.zero_out, 1'b1);
    check("to_x", bus_to.x_out, '0);
    @(posedge clk_in); #1;
    check("to_release_ready", bus_to.ready_out, 1'b1);

    // next vector on the timeout instance completes normally
    bus_to.x_in = 32'h0003_0000; bus_to.y_in = 32'h0004_0000; bus_to.z_in = '0;
    bus_to.valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus_to.valid_in = 1'b0;
    n = 0;
    while (!bus_to.isqrt_valid_out && n < 10) begin
      @(posedge clk_in); #1; n++;
    end
    check("to2_isqrt_a", bus_to.isqrt_a_out, 32'h0019_0000);
    @(posedge clk_in); #1;
    bus_to.isqrt_valid_in = 1'b1;
    bus_to.isqrt_res_in   = 32'd13107;
    @(posedge clk_in); #1;
    bus_to.isqrt_valid_in = 1'b0;
    n = 0;
    while (!bus_to.valid_out && n < 20) begin
      @(posedge clk_in); #1; n++;
    end
    check("to2_valid_seen", bus_to.valid_out, 1'b1);
    check("to2_x", bus_to.x_out, 32'd39321);
    check("to2_y", bus_to.y_out, 32'd52428);
    check("to2_zero", bus_to.zero_out, 1'b0);

    repeat (3) @(posedge clk_in);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
